// File: rtl/de0_nano_debug_display.sv
// DE0-Nano debug display harness: debounced advance button, synchronised mode
// switches, and a registered LED view of NUM_CH debug channels paged LED_W
// bits at a time, plus frozen-snapshot, heartbeat and valid-map views.
module de0_nano_debug_display #(
  parameter int NUM_CH        = 4,
  parameter int DATA_W        = 32,
  parameter int LED_W         = 8,
  parameter int DEBOUNCE_CYC  = 500000,
  parameter int HEARTBEAT_CYC = 25000000,
  localparam int PAGES = (DATA_W + LED_W - 1) / LED_W,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PG_W  = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                     CLOCK_50,
  input  logic                     KEY0,
  input  logic                     KEY1,
  input  logic [1:0]               SW,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [LED_W-1:0]         LED,
  output logic [CH_W-1:0]          cur_ch,
  output logic [PG_W-1:0]          cur_page,
  output logic                     key_pulse
);

  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HB_W  = (HEARTBEAT_CYC > 1) ? $clog2(HEARTBEAT_CYC) : 1;
  localparam int PTR_W = CH_W + PG_W;
  localparam int PX_W  = (PTR_W > LED_W - 1) ? PTR_W : LED_W - 1;
  localparam int VX_W  = (NUM_CH > LED_W) ? NUM_CH : LED_W;

  typedef enum logic [1:0] {
    M_LIVE   = 2'b00,
    M_FROZEN = 2'b01,
    M_HB     = 2'b10,
    M_VALID  = 2'b11
  } mode_e;

  logic                            r_run;
  logic                            r_key_s1, r_key_s2;
  logic [1:0]                      r_sw_s1, r_sw_s2;
  logic                            r_db_state;
  logic [DB_W-1:0]                 r_db_cnt;
  logic                            r_key_pulse;
  logic [CH_W-1:0]                 r_cur_ch;
  logic [PG_W-1:0]                 r_cur_page;
  mode_e                           r_mode_q;
  logic                            r_snap_ld;
  logic [DATA_W-1:0]               r_snap;
  logic [HB_W-1:0]                 r_hb_cnt;
  logic                            r_hb;
  logic [LED_W-1:0]                r_led;

  mode_e                           w_mode;
  logic                            w_db_hit;
  logic                            w_last_pg, w_last_ch;
  logic [NUM_CH-1:0][DATA_W-1:0]   w_ch_arr;
  logic [DATA_W-1:0]               w_cur_data;
  logic [PX_W-1:0]                 w_ptr_x;
  logic [VX_W-1:0]                 w_vld_x;
  logic [LED_W-1:0]                w_led_nxt;

  // Page p of a channel word; bits past DATA_W-1 read as zero.
  function automatic logic [LED_W-1:0] page_of(input logic [DATA_W-1:0] d,
                                               input logic [PG_W-1:0]   p);
    logic [PAGES*LED_W-1:0] pad;
    logic [LED_W-1:0]       r;
    pad             = '0;
    pad[DATA_W-1:0] = d;
    r               = '0;
    for (int i = 0; i < PAGES; i++)
      if (p == PG_W'(i)) r = pad[i*LED_W +: LED_W];
    return r;
  endfunction

  assign w_mode    = mode_e'(r_sw_s2);
  assign w_ch_arr  = ch_data;
  assign w_db_hit  = (r_key_s2 != r_db_state) && (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1));
  assign w_last_pg = (r_cur_page == PG_W'(PAGES - 1));
  assign w_last_ch = (r_cur_ch == CH_W'(NUM_CH - 1));
  assign w_ptr_x   = PX_W'({r_cur_ch, r_cur_page});
  assign w_vld_x   = VX_W'(ch_valid);

  // Reset release is held off one cycle so nothing moves right after KEY0 rises.
  always_ff @(posedge CLOCK_50 or negedge KEY0)
    if (!KEY0) r_run <= 1'b0;
    else       r_run <= 1'b1;

  // Two-flop synchronisers for the asynchronous button and switches.
  always_ff @(posedge CLOCK_50 or negedge KEY0)
    if (!KEY0) begin
      r_key_s1 <= 1'b1;
      r_key_s2 <= 1'b1;
      r_sw_s1  <= 2'b00;
      r_sw_s2  <= 2'b00;
    end else if (r_run) begin
      r_key_s1 <= KEY1;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= SW;
      r_sw_s2  <= r_sw_s1;
    end

  // Debounce: the synced level must differ for DEBOUNCE_CYC cycles to be accepted;
  // an accepted press (1->0) emits a single-cycle strobe.
  always_ff @(posedge CLOCK_50 or negedge KEY0)
    if (!KEY0) begin
      r_db_state  <= 1'b1;
      r_db_cnt    <= '0;
      r_key_pulse <= 1'b0;
    end else if (r_run) begin
      r_key_pulse <= w_db_hit && !r_key_s2;
      if (r_key_s2 == r_db_state) begin
        r_db_cnt <= '0;
      end else if (w_db_hit) begin
        r_db_state <= r_key_s2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end

  // Page/channel pointer steps on each accepted press, wrapping page then channel.
  always_ff @(posedge CLOCK_50 or negedge KEY0)
    if (!KEY0) begin
      r_cur_ch   <= '0;
      r_cur_page <= '0;
    end else if (r_run && r_key_pulse) begin
      if (w_last_pg) begin
        r_cur_page <= '0;
        r_cur_ch   <= w_last_ch ? '0 : r_cur_ch + 1'b1;
      end else begin
        r_cur_page <= r_cur_page + 1'b1;
      end
    end

  // Snapshot reloads one cycle after entering frozen mode or after a press in it,
  // by which time the pointer already reflects the press.
  always_ff @(posedge CLOCK_50 or negedge KEY0)
    if (!KEY0) begin
      r_mode_q  <= M_LIVE;
      r_snap_ld <= 1'b0;
      r_snap    <= '0;
    end else if (r_run) begin
      r_mode_q  <= w_mode;
      r_snap_ld <= (w_mode == M_FROZEN) && ((r_mode_q != M_FROZEN) || r_key_pulse);
      if (r_snap_ld) r_snap <= w_cur_data;
    end

  // Heartbeat runs only while displayed; leaving the mode restarts it from zero.
  always_ff @(posedge CLOCK_50 or negedge KEY0)
    if (!KEY0) begin
      r_hb_cnt <= '0;
      r_hb     <= 1'b0;
    end else if (r_run) begin
      if (w_mode == M_HB) begin
        if (r_hb_cnt == HB_W'(HEARTBEAT_CYC - 1)) begin
          r_hb_cnt <= '0;
          r_hb     <= ~r_hb;
        end else begin
          r_hb_cnt <= r_hb_cnt + 1'b1;
        end
      end else begin
        r_hb_cnt <= '0;
        r_hb     <= 1'b0;
      end
    end

  // Select the current channel word and build the next LED value for the mode.
  always_comb begin
    w_cur_data = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (r_cur_ch == CH_W'(c)) w_cur_data = w_ch_arr[c];
    w_led_nxt = '0;
    case (w_mode)
      M_LIVE:   w_led_nxt = page_of(w_cur_data, r_cur_page);
      M_FROZEN: w_led_nxt = page_of(r_snap, r_cur_page);
      M_HB:     w_led_nxt = {r_hb, w_ptr_x[LED_W-2:0]};
      default:  w_led_nxt = w_vld_x[LED_W-1:0];
    endcase
  end

  // Registered LED drive.
  always_ff @(posedge CLOCK_50 or negedge KEY0)
    if (!KEY0)      r_led <= '0;
    else if (r_run) r_led <= w_led_nxt;

  assign LED       = r_led;
  assign cur_ch    = r_cur_ch;
  assign cur_page  = r_cur_page;
  assign key_pulse = r_key_pulse;

endmodule

// File: tb/tb_de0_nano_debug_display.sv
// Scoreboard bench: stimulus pushes expectations derived from a behavioural
// model; a negedge monitor pops and compares them, and checks every key_pulse.
module tb_de0_nano_debug_display;
  localparam int NUM_CH = 3, DATA_W = 20, LED_W = 8, DEB = 4, HB = 8, PAGES = 3;

  logic                     clk = 1'b0;
  logic                     key0 = 1'b0, key1 = 1'b1;
  logic [1:0]               sw = 2'b00;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;
  logic [NUM_CH-1:0]        ch_valid = '0;
  logic [LED_W-1:0]         led;
  logic [1:0]               cur_ch, cur_page;
  logic                     key_pulse;

  de0_nano_debug_display #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LED_W(LED_W),
    .DEBOUNCE_CYC(DEB), .HEARTBEAT_CYC(HB)
  ) dut (
    .CLOCK_50(clk), .KEY0(key0), .KEY1(key1), .SW(sw),
    .ch_data(ch_data), .ch_valid(ch_valid),
    .LED(led), .cur_ch(cur_ch), .cur_page(cur_page), .key_pulse(key_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic [7:0] msk;
    logic [1:0] ch;
    logic [1:0] pg;
  } chk_t;

  chk_t        chk_q[$];
  string       nm_q[$];
  logic [3:0]  pulse_q[$];
  int          hb_q[$];
  int          n_chk = 0, n_fail = 0, cyc_n = 0;
  bit          in_hb = 0;

  // behavioural model state
  int unsigned mdata[NUM_CH];
  int unsigned msnap;
  int          mc, mp, mmode;

  always @(posedge clk) cyc_n++;

  function automatic logic [7:0] pg_of(int unsigned d, int p);
    int unsigned v;
    v = (d & 32'hFFFFF) >> (p * 8);
    return v[7:0];
  endfunction

  function automatic logic [7:0] exp_led();
    case (mmode)
      0:       return pg_of(mdata[mc], mp);
      1:       return pg_of(msnap, mp);
      2:       return {1'b0, 7'(mc * 4 + mp)};
      default: return {5'b0, ch_valid};
    endcase
  endfunction

  task automatic drive_data();
    for (int c = 0; c < NUM_CH; c++) ch_data[c*DATA_W +: DATA_W] = mdata[c][DATA_W-1:0];
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_m(string nm, logic [7:0] l, logic [7:0] m);
    chk_t e;
    e.led = l; e.msk = m; e.ch = 2'(mc); e.pg = 2'(mp);
    chk_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic expect_now(string nm);
    expect_m(nm, exp_led(), (mmode == 2) ? 8'h7F : 8'hFF);
  endtask

  // A press held for at least DEB cycles is accepted exactly once.
  task automatic press(int len, string nm);
    if (len >= DEB) begin
      if (mp == PAGES - 1) begin
        mp = 0;
        mc = (mc + 1) % NUM_CH;
      end else mp = mp + 1;
      if (mmode == 1) msnap = mdata[mc];
      pulse_q.push_back({2'(mc), 2'(mp)});
    end
    key1 = 1'b0;
    cyc(len);
    key1 = 1'b1;
    cyc(20);
    n_chk++;
    if (pulse_q.size() != 0) begin
      n_fail++;
      $display("FAIL pulse_missing(%s): %0d expected pulse(s) never seen", nm, pulse_q.size());
      pulse_q.delete();
    end
    expect_now(nm);
  endtask

  // monitor
  logic [3:0] kp_exp;
  bit         kp_pend = 0, hb_arm = 0;
  logic       hb_prev;
  always @(negedge clk) begin
    if (in_hb) begin
      if (hb_arm && led[7] !== hb_prev) hb_q.push_back(cyc_n);
      hb_prev = led[7];
      hb_arm  = 1;
    end else hb_arm = 0;

    while (chk_q.size() > 0) begin
      chk_t  e;
      string nm;
      e  = chk_q.pop_front();
      nm = nm_q.pop_front();
      n_chk++;
      if ((led & e.msk) !== (e.led & e.msk) || cur_ch !== e.ch ||
          cur_page !== e.pg || key_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL %s: got LED=%h ch=%0d pg=%0d kp=%b, want LED=%h(mask %h) ch=%0d pg=%0d kp=0",
                 nm, led, cur_ch, cur_page, key_pulse, e.led, e.msk, e.ch, e.pg);
      end
    end

    if (kp_pend) begin
      n_chk++;
      if ({cur_ch, cur_page} !== kp_exp) begin
        n_fail++;
        $display("FAIL pulse_ptr: got ch=%0d pg=%0d, want ch=%0d pg=%0d",
                 cur_ch, cur_page, kp_exp[3:2], kp_exp[1:0]);
      end
      kp_pend = 0;
    end
    if (key_pulse === 1'b1) begin
      n_chk++;
      if (pulse_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got key_pulse=1 at cycle %0d, want 0", cyc_n);
      end else begin
        kp_exp  = pulse_q.pop_front();
        kp_pend = 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int t0, d1, t1;
    bit found;
    mc = 0; mp = 0; mmode = 0; msnap = 0;
    for (int c = 0; c < NUM_CH; c++) mdata[c] = $urandom & 32'hFFFFF;
    mdata[0] = 32'hABCDE;
    drive_data();
    cyc(2);
    expect_m("reset_state", 8'h00, 8'hFF);
    cyc(1);
    key0 = 1'b1;
    cyc(1);
    expect_m("release_quiet", 8'h00, 8'hFF);
    cyc(6);
    expect_m("live_DE", 8'hDE, 8'hFF);

    // debounce and paging
    press(3, "glitch3");
    press(10, "press_p1");
    expect_m("live_BC", 8'hBC, 8'hFF);
    press($urandom_range(5, 40), "press_p2");
    expect_m("live_0A", 8'h0A, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      press($urandom_range(1, 3), "glitch_rand");
      press($urandom_range(5, 40), "press_rand");
    end
    for (int i = 0; i < 4; i++) begin
      mdata[$urandom_range(0, NUM_CH - 1)] = $urandom & 32'hFFFFF;
      drive_data();
      cyc(3);
      expect_now("live_rand");
    end
    press(100, "hold100_wrap");

    // frozen snapshot
    mdata[0] = 32'h12345;
    drive_data();
    cyc(3);
    expect_m("live_45", 8'h45, 8'hFF);
    sw = 2'b01; mmode = 1; msnap = mdata[mc];
    cyc(8);
    expect_m("frozen_45", 8'h45, 8'hFF);
    mdata[0] = 0;
    drive_data();
    cyc(4);
    expect_m("frozen_hold", 8'h45, 8'hFF);
    for (int i = 0; i < 3; i++) press($urandom_range(5, 40), "frozen_press");
    mdata[1] = $urandom & 32'hFFFFF;
    drive_data();
    cyc(4);
    expect_now("frozen_ch1_hold");

    // heartbeat
    sw = 2'b10; mmode = 2; t0 = cyc_n;
    cyc(4);
    expect_m("hb_start", {1'b0, 7'(mc * 4 + mp)}, 8'hFF);
    hb_q.delete(); in_hb = 1;
    cyc(40);
    in_hb = 0;
    n_chk++;
    if (hb_q.size() < 4) begin
      n_fail++;
      $display("FAIL hb_toggles: got %0d toggles in 40 cycles, want >= 4", hb_q.size());
    end else begin
      d1 = hb_q[0] - t0;
      n_chk++;
      if (d1 < 8 || d1 > 14) begin
        n_fail++;
        $display("FAIL hb_first: got first toggle %0d cycles after entry, want 8..14", d1);
      end
      for (int i = 1; i < hb_q.size(); i++) begin
        n_chk++;
        if (hb_q[i] - hb_q[i-1] != HB) begin
          n_fail++;
          $display("FAIL hb_period: got %0d cycles, want %0d", hb_q[i] - hb_q[i-1], HB);
        end
      end
    end
    press($urandom_range(5, 40), "hb_press");
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (led[7] === 1'b1) found = 1;
      else cyc(1);
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL hb_high: got LED[7]=0 for 20 cycles, want a 1");
    end
    sw = 2'b00; mmode = 0;
    cyc(6);
    expect_now("hb_away_live");
    sw = 2'b10; mmode = 2; t1 = cyc_n;
    cyc(4);
    expect_m("hb_restart", {1'b0, 7'(mc * 4 + mp)}, 8'hFF);
    hb_q.delete(); in_hb = 1;
    cyc(20);
    in_hb = 0;
    n_chk++;
    if (hb_q.size() < 1 || hb_q[0] - t1 != d1) begin
      n_fail++;
      $display("FAIL hb_restart_phase: got %0d toggles, first at %0d, want first at %0d",
               hb_q.size(), (hb_q.size() > 0) ? hb_q[0] - t1 : -1, d1);
    end

    // valid map
    sw = 2'b11; mmode = 3; ch_valid = 3'b101;
    cyc(5);
    expect_m("valid_05", 8'h05, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      ch_valid = 3'($urandom);
      cyc(3);
      expect_now("valid_rand");
    end

    // reset in the middle of a debounce
    key1 = 1'b0;
    cyc(3);
    key0 = 1'b0;
    mc = 0; mp = 0; msnap = 0;
    #1;
    expect_m("async_reset", 8'h00, 8'hFF);
    cyc(2);
    key0 = 1'b1;
    cyc(3);
    key1 = 1'b1;
    cyc(20);
    expect_now("post_reset_valid");
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
